// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared funct3 encodings, FSM state type and the illegal-funct3
//               decode for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } lsu_state_e;

    // Stores only have B/H/W; loads additionally have BU/HU.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 > F3_W);
        end
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational byte-lane logic: load extraction with sign/zero
//               extension and store merge into the old memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Half accesses only look at addr[1], so an unaligned half silently rounds down.
    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

        o_load_data = i_word;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = i_word;
        endcase

        o_store_word = i_word;
        case (i_funct3)
            F3_B: begin
                case (i_addr_lo)
                    2'd0: o_store_word[7:0]   = i_wdata[7:0];
                    2'd1: o_store_word[15:8]  = i_wdata[7:0];
                    2'd2: o_store_word[23:16] = i_wdata[7:0];
                    2'd3: o_store_word[31:24] = i_wdata[7:0];
                    default: o_store_word[7:0] = i_wdata[7:0];
                endcase
            end
            F3_H: begin
                if (i_addr_lo[1]) begin
                    o_store_word[31:16] = i_wdata[15:0];
                end else begin
                    o_store_word[15:0] = i_wdata[15:0];
                end
            end
            default: o_store_word = i_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : MEM-stage data-memory initiator. One request in flight, single
//               response per request. Define LSU_MISALIGN_TRAP_EN to fault
//               misaligned half/word accesses instead of rounding them down.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_exc,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    lsu_state_e  r_state_q,  w_state_d;
    logic [2:0]  r_funct3_q, w_funct3_d;
    logic [31:0] r_addr_q,   w_addr_d;
    logic [31:0] r_wdata_q,  w_wdata_d;
    logic [31:0] r_data_q,   w_data_d;
    logic        r_exc_q,    w_exc_d;

    logic        w_misalign;
    logic        w_fault;
    logic [31:0] w_word_addr;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        w_misalign = 1'b0;
        case (i_req_funct3)
            F3_H, F3_HU: w_misalign = i_req_addr[0];
            F3_W:        w_misalign = |i_req_addr[1:0];
            default:     w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault     = f3_illegal(i_req_we, i_req_funct3) | w_misalign;
    assign w_word_addr = {r_addr_q[31:2], 2'b00};

    lsu_align u_align (
        .i_word       (i_mem_rdata),
        .i_addr_lo    (r_addr_q[1:0]),
        .i_funct3     (r_funct3_q),
        .i_wdata      (r_wdata_q),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    // r_data_q carries the load result in RESP, and the word to write in WRITE.
    always_comb begin
        w_state_d  = r_state_q;
        w_funct3_d = r_funct3_q;
        w_addr_d   = r_addr_q;
        w_wdata_d  = r_wdata_q;
        w_data_d   = r_data_q;
        w_exc_d    = r_exc_q;

        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_rsp_rdata = 32'd0;
        o_rsp_exc   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = 32'd0;
        o_mem_wdata = 32'd0;

        case (r_state_q)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_funct3_d = i_req_funct3;
                    w_addr_d   = i_req_addr;
                    w_wdata_d  = i_req_wdata;
                    w_data_d   = 32'd0;
                    w_exc_d    = w_fault;
                    if (w_fault) begin
                        w_state_d = S_RESP;
                    end else if (!i_req_we) begin
                        w_state_d = S_LOAD;
                    end else if (i_req_funct3 == F3_W) begin
                        w_state_d = S_WRITE;
                        w_data_d  = i_req_wdata;
                    end else begin
                        w_state_d = S_READ;
                    end
                end
            end
            S_LOAD: begin
                o_mem_addr = w_word_addr;
                w_data_d   = w_load_data;
                w_state_d  = S_RESP;
            end
            S_READ: begin
                o_mem_addr = w_word_addr;
                w_data_d   = w_store_word;
                w_state_d  = S_WRITE;
            end
            S_WRITE: begin
                o_mem_we    = 1'b1;
                o_mem_addr  = w_word_addr;
                o_mem_wdata = r_data_q;
                w_data_d    = 32'd0;
                w_state_d   = S_RESP;
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_rdata = r_data_q;
                o_rsp_exc   = r_exc_q;
                if (i_rsp_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        // Reset silences every output in the same cycle, before the edge.
        if (i_rst) begin
            o_req_ready = 1'b0;
            o_rsp_valid = 1'b0;
            o_rsp_rdata = 32'd0;
            o_rsp_exc   = 1'b0;
            o_mem_we    = 1'b0;
            o_mem_addr  = 32'd0;
            o_mem_wdata = 32'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q  <= S_IDLE;
            r_funct3_q <= 3'd0;
            r_addr_q   <= 32'd0;
            r_wdata_q  <= 32'd0;
            r_data_q   <= 32'd0;
            r_exc_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_funct3_q <= w_funct3_d;
            r_addr_q   <= w_addr_d;
            r_wdata_q  <= w_wdata_d;
            r_data_q   <= w_data_d;
            r_exc_q    <= w_exc_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface in the RISC-V MEM stage. Accepts one load/store request at a time from the pipeline and drives a word-addressed data memory. The memory has a combinational read and a write on the clock edge. The unit performs byte-lane extraction with sign/zero extension for loads and read-modify-write for sub-word stores. It also flags illegal and misaligned accesses, then returns a single response per request under a valid/ready handshake.

## Interface
- No parameters; data and address widths are fixed at 32.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  unit can accept a request.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_funct3  in  3  RISC-V funct3: load 0/1/2/4/5 = LB/LH/LW/LBU/LHU; store 0/1/2 = SB/SH/SW.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data; the low byte or half is used for SB/SH.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  pipeline consumes the response.
- o_rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and exceptions.
- o_rsp_exc  out  1  access faulted; no memory write took place.
- o_mem_we  out  1  memory write strobe.
- o_mem_addr  out  32  byte address, always word-aligned ([1:0]=0).
- o_mem_wdata  out  32  full word to write.
- i_mem_rdata  in  32  word at o_mem_addr, valid in the same cycle.

## Operation
- States: IDLE, LOAD, READ, WRITE, RESP.
- IDLE:
  - o_req_ready = 1 (forced to 0 while i_rst is high).
  - On i_req_valid & o_req_ready, capture we, funct3, addr and wdata.
  - Then go to RESP with exc if the access faults, else LOAD (load), WRITE (SW), or READ (SB/SH).
- LOAD: o_mem_addr = {addr[31:2],2'b00}. Sample i_mem_rdata and extract the lane selected by addr[1:0].
  - Byte: lane addr[1:0]. Half: lane addr[1].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - Go to RESP.
- READ: sample the word, merge the store lane into it, go to WRITE.
- WRITE: o_mem_we = 1 for exactly this cycle. o_mem_wdata holds the merged word, or i_req_wdata for SW. Go to RESP.
- RESP: o_rsp_valid = 1, and o_rsp_rdata/o_rsp_exc are held stable until i_rsp_ready is sampled high; then go to IDLE.
- No new request is accepted in the RESP cycle. A request is accepted no earlier than the cycle after the handshake.
- Illegal funct3:
  - Loads 3/6/7 and stores 3–7 give o_rsp_exc = 1.
  - No memory access occurs. This applies in every configuration.
- Outside LOAD, READ and WRITE: o_mem_addr = 0, o_mem_wdata = 0, o_mem_we = 0.

## Timing
- Request accepted at edge T. The response is valid in the cycle after edge T+n:
  - exception: T+1 (RESP directly)
  - load / SW: T+2
  - SB/SH: T+3
- o_mem_we is only ever high in the WRITE state and is gated with !i_rst.
- Reset asserted in any cycle:
  - No memory write in that cycle.
  - State returns to IDLE at the edge and the captured request is dropped.
  - Every output is 0 while reset is high.
  - After release: o_req_ready = 1, all other outputs 0.
- Back-pressure: RESP may last any number of cycles, and the memory is not re-accessed while it does.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned accesses fault: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0.
  - The response is o_rsp_exc = 1 at T+1 and no memory access occurs.
- LSU_MISALIGN_TRAP_EN undefined:
  - The low address bits are cleared to the access size (half: [0]; word: [1:0]) and the access proceeds normally.
  - Misalignment never raises o_rsp_exc.

## Structure
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum.
- Sub-module lsu_align (combinational):
  - load path: word + addr[1:0] + funct3 → extended result.
  - store path: old word + wdata + addr[1:0] + funct3 → merged word.
- The FSM and the capture registers live in load_store_unit.

## Test plan
Memory word 0x40 is preloaded with 0x8899AABB; i_rsp_ready = 1 unless stated.
- LB addr 0x41 → o_rsp_rdata = 0xFFFFFFAA, o_rsp_valid at T+2, o_mem_we never high.
- LBU addr 0x43 → 0x00000088; LHU addr 0x42 → 0x00008899; LH addr 0x40 → 0xFFFFAABB.
- SB addr 0x42, wdata 0x12345611 → o_mem_we high for exactly one cycle (T+2) with o_mem_addr 0x40, o_mem_wdata 0x8811AABB; response at T+3 with exc = 0.
- SW addr 0x44, wdata 0xDEADBEEF → o_mem_we at T+1; hold i_rsp_ready = 0 for 3 cycles → o_rsp_valid stays high, no second write, o_req_ready stays 0.
- LW addr 0x42:
  - with LSU_MISALIGN_TRAP_EN → exc = 1 at T+1, rdata 0, no access.
  - without it → 0x8899AABB at T+2.
  - funct3 = 3 load → exc in both builds.
- SH addr 0x40 with i_rst raised in the READ cycle → o_mem_we never asserts, the word stays 0x8899AABB, and o_req_ready = 1 the cycle after reset drops.
